// File: rtl/btb_pkg.sv
// -----------------------------------------------------------------------------
// btb_pkg
// Shared types and constants for the branch target buffer.
//   branchpredict_t     : resolution/update record coming from the EX stage
//   branchpredict_sbe_t : prediction hint handed to the fetch stage
//   btb_entry_t         : logical layout of one table entry
// Optional feature macro: BTB_TAG_EN adds a partial PC tag to each entry.
// -----------------------------------------------------------------------------
package btb_pkg;

  localparam int BTB_ENTRIES  = 64;
  localparam int BTB_SAT_BITS = 2;
  localparam int BTB_TAG_BITS = 16;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] target_address;
    logic        is_mispredict;
    logic        is_taken;
    logic        is_lower_16;
    logic        clear;
  } branchpredict_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] predict_address;
    logic        predict_taken;
    logic        is_lower_16;
  } branchpredict_sbe_t;

  typedef struct packed {
`ifdef BTB_TAG_EN
    logic [BTB_TAG_BITS-1:0] tag;
`endif
    logic                    valid;
    logic [63:0]             target_address;
    logic                    is_lower_16;
    logic [BTB_SAT_BITS-1:0] saturation_counter;
  } btb_entry_t;

endpackage

// File: rtl/btb_sat_counter.sv
// -----------------------------------------------------------------------------
// btb_sat_counter
// Per-entry saturating taken/not-taken direction counter.
// Ports:
//   clk_i, rst_ni  : clock, synchronous active-low reset (counter -> 0)
//   flush_i        : force counter to 0
//   init_i         : load weakly-taken / weakly-not-taken start value
//   init_taken_i   : selects weakly-taken (1) or weakly-not-taken (0) on init
//   inc_i, dec_i   : saturating step up / down
//   cnt_o          : current counter value
// -----------------------------------------------------------------------------
module btb_sat_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             init_i,
  input  logic             init_taken_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] cnt_o
);

  // Weakly taken is the MSB alone; weakly not-taken sits just below it.
  localparam logic [WIDTH-1:0] WEAK_TAKEN     = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] WEAK_NOT_TAKEN = WEAK_TAKEN - WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX        = '1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (flush_i) begin
      cnt_o <= '0;
    end else if (init_i) begin
      cnt_o <= init_taken_i ? WEAK_TAKEN : WEAK_NOT_TAKEN;
    end else if (inc_i && (cnt_o != CNT_MAX)) begin
      cnt_o <= cnt_o + WIDTH'(1);
    end else if (dec_i && (cnt_o != '0)) begin
      cnt_o <= cnt_o - WIDTH'(1);
    end
  end

endmodule

// File: rtl/btb.sv
// -----------------------------------------------------------------------------
// btb
// Direct-mapped branch target buffer for the fetch stage. Lookup is purely
// combinational from registered state; updates from EX commit on the next
// clock edge, so a same-cycle lookup of the updated index sees old contents.
// Ports:
//   clk_i            : clock
//   rst_ni           : synchronous active-low reset, dominates flush and update
//   flush_i          : invalidate every entry and zero its counter
//   vpc_i            : fetch PC to look up
//   branchpredict_i  : resolution/update from EX
//   branch_predict_o : prediction for vpc_i ('0 on a miss)
// Optional feature macro: BTB_TAG_EN stores pc[OFFSET+IDX +: 16] as a tag so
// that aliasing PCs miss instead of sharing an entry.
// -----------------------------------------------------------------------------
module btb
  import btb_pkg::*;
#(
  parameter int NR_ENTRIES              = BTB_ENTRIES,
  parameter int BITS_SATURATION_COUNTER = BTB_SAT_BITS,
  parameter int OFFSET                  = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic [63:0]        vpc_i,
  input  branchpredict_t     branchpredict_i,
  output branchpredict_sbe_t branch_predict_o
);

  localparam int IDX = $clog2(NR_ENTRIES);
  localparam int B   = BITS_SATURATION_COUNTER;

  logic [NR_ENTRIES-1:0] valid_q;
  logic [NR_ENTRIES-1:0] lower_q;
  logic [63:0]           target_q [NR_ENTRIES];
  logic [B-1:0]          cnt_q    [NR_ENTRIES];

  logic [IDX-1:0]        lookup_idx;
  logic [IDX-1:0]        update_idx;
  logic                  lookup_hit;
  logic                  update_hit;
  logic                  update_go;
  logic [NR_ENTRIES-1:0] init_vec;
  logic [NR_ENTRIES-1:0] inc_vec;
  logic [NR_ENTRIES-1:0] dec_vec;

  // Only the index (and tag) slices of the PCs are consumed; the rest of the
  // bus, including is_mispredict, is informational for this block.
  logic unused_bits;
  assign unused_bits = ^{vpc_i, branchpredict_i};

  assign lookup_idx = vpc_i[OFFSET +: IDX];
  assign update_idx = branchpredict_i.pc[OFFSET +: IDX];
  assign update_go  = branchpredict_i.valid && !flush_i;

`ifdef BTB_TAG_EN
  logic [BTB_TAG_BITS-1:0] tag_q [NR_ENTRIES];
  logic [BTB_TAG_BITS-1:0] lookup_tag;
  logic [BTB_TAG_BITS-1:0] update_tag;

  assign lookup_tag = vpc_i[OFFSET+IDX +: BTB_TAG_BITS];
  assign update_tag = branchpredict_i.pc[OFFSET+IDX +: BTB_TAG_BITS];
  assign lookup_hit = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
  // A tag mismatch makes the update behave like an allocation.
  assign update_hit = valid_q[update_idx] && (tag_q[update_idx] == update_tag);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_ENTRIES; i++) tag_q[i] <= '0;
    end else if (update_go && !branchpredict_i.clear && !update_hit) begin
      tag_q[update_idx] <= update_tag;
    end
  end
`else
  assign lookup_hit = valid_q[lookup_idx];
  assign update_hit = valid_q[update_idx];
`endif

  // Prediction: the counter MSB is the taken/not-taken decision.
  always_comb begin
    branch_predict_o = '0;
    if (lookup_hit) begin
      branch_predict_o.valid           = 1'b1;
      branch_predict_o.predict_address = target_q[lookup_idx];
      branch_predict_o.predict_taken   = cnt_q[lookup_idx][B-1];
      branch_predict_o.is_lower_16     = lower_q[lookup_idx];
    end
  end

  // Counter steering: allocate on a miss, otherwise step toward the outcome.
  always_comb begin
    init_vec = '0;
    inc_vec  = '0;
    dec_vec  = '0;
    if (update_go && !branchpredict_i.clear) begin
      if (!update_hit) begin
        init_vec[update_idx] = 1'b1;
      end else if (branchpredict_i.is_taken) begin
        inc_vec[update_idx] = 1'b1;
      end else begin
        dec_vec[update_idx] = 1'b1;
      end
    end
  end

  // Valid bits and targets. A not-taken outcome keeps the stored target.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      lower_q <= '0;
      for (int i = 0; i < NR_ENTRIES; i++) target_q[i] <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (branchpredict_i.valid) begin
      if (branchpredict_i.clear) begin
        valid_q[update_idx] <= 1'b0;
      end else begin
        valid_q[update_idx] <= 1'b1;
        if (branchpredict_i.is_taken) begin
          target_q[update_idx] <= branchpredict_i.target_address;
          lower_q[update_idx]  <= branchpredict_i.is_lower_16;
        end
      end
    end
  end

  for (genvar g = 0; g < NR_ENTRIES; g++) begin : g_cnt
    btb_sat_counter #(
      .WIDTH(B)
    ) u_cnt (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .init_i      (init_vec[g]),
      .init_taken_i(branchpredict_i.is_taken),
      .inc_i       (inc_vec[g]),
      .dec_i       (dec_vec[g]),
      .cnt_o       (cnt_q[g])
    );
  end

endmodule
